// File: rtl/wb_router_18.sv
// Seven-way in-order router: a DEPTH-entry FIFO of {dest, data} feeds a shared
// output bus with a one-hot valid per destination; illegal destinations are dropped and flagged.
module wb_router_18 #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [2:0]               in_dest,
   output logic [6:0]               out_valid,
   input  logic [6:0]               out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     err_dest,
   input  logic                     err_clr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] data_mem_q [DEPTH];
   logic [2:0]       dest_mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             err_q, err_d;

   logic             accept_s, push_s, drop_s, pop_s, nonempty_s;
   logic [2:0]       head_dest_s;
   logic [7:0]       ready_ext_s;

   // Handshake decode; pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      nonempty_s  = (count_q != {CW{1'b0}});
      head_dest_s = dest_mem_q[rd_ptr_q];
      ready_ext_s = {1'b0, out_ready};
      in_ready    = (count_q < CW'(DEPTH));
      accept_s    = in_valid & in_ready;
      push_s      = accept_s & (in_dest != 3'd7);
      drop_s      = accept_s & (in_dest == 3'd7);
      pop_s       = nonempty_s & ready_ext_s[head_dest_s];

      wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A new illegal word outranks a clear in the same cycle.
      if (drop_s) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // Outputs derive only from state, so nothing passes combinationally from in_* to out_*.
   always_comb begin
      if (nonempty_s) begin
         out_valid = 7'd1 << head_dest_s;
         out_data  = data_mem_q[rd_ptr_q];
      end else begin
         out_valid = 7'd0;
         out_data  = {WIDTH{1'b0}};
      end
      count    = count_q;
      err_dest = err_q;
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   // Payload storage is left unreset; out_data is masked while empty.
   always_ff @(posedge clk) begin
      if (push_s) begin
         data_mem_q[wr_ptr_q] <= in_data;
         dest_mem_q[wr_ptr_q] <= in_dest;
      end
   end

endmodule

// File: tb/tb_wb_router_18.sv
// Directed self-checking bench for wb_router_18 with hand-computed expectations.
module tb_wb_router_18;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] in_data;
   logic [2:0]  in_dest;
   logic [6:0]  out_valid;
   logic [6:0]  out_ready;
   logic [17:0] out_data;
   logic        err_dest;
   logic        err_clr;
   logic [1:0]  count;

   int errors = 0;
   int checks = 0;

   wb_router_18 #(.WIDTH(18), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .err_dest(err_dest), .err_clr(err_clr), .count(count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = 18'd0; in_dest = 3'd0;
      out_ready = 7'd0; err_clr = 1'b0;
      #2;
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (out_valid !== 7'h00) begin errors++; $display("FAIL reset_out_valid got %h exp 00", out_valid); end
      checks++; if (out_data !== 18'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
      checks++; if (err_dest !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_dest); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_data = 18'h2AAAA; in_dest = 3'd3; out_ready = 7'h08;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 7'h08) begin errors++; $display("FAIL single_valid got %h exp 08", out_valid); end
      checks++; if (out_data !== 18'h2AAAA) begin errors++; $display("FAIL single_data got %h exp 2aaaa", out_data); end
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
      step();
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL single_pop_count got %0d exp 0", count); end
      checks++; if (out_valid !== 7'h00) begin errors++; $display("FAIL single_pop_valid got %h exp 00", out_valid); end
      checks++; if (out_data !== 18'h0) begin errors++; $display("FAIL single_empty_data got %h exp 0", out_data); end
      out_ready = 7'h00;
   endtask

   task automatic test_full();
      out_ready = 7'h00;
      in_valid = 1'b1; in_data = 18'h00001; in_dest = 3'd0;
      step();
      in_data = 18'h00002; in_dest = 3'd6;
      step();
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_count got %0d exp 2", count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
      in_data = 18'h00003; in_dest = 3'd1;
      step();
      in_valid = 1'b0;
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_third_count got %0d exp 2", count); end
      checks++; if (out_valid !== 7'h01) begin errors++; $display("FAIL full_head_valid got %h exp 01", out_valid); end
      checks++; if (out_data !== 18'h00001) begin errors++; $display("FAIL full_head_data got %h exp 1", out_data); end
      out_ready = 7'h7E;
      step();
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_other_ready_count got %0d exp 2", count); end
      checks++; if (out_valid !== 7'h01) begin errors++; $display("FAIL full_other_ready_valid got %h exp 01", out_valid); end
      out_ready = 7'h01;
      step();
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL full_pop0_count got %0d exp 1", count); end
      checks++; if (out_valid !== 7'h40) begin errors++; $display("FAIL full_next_valid got %h exp 40", out_valid); end
      checks++; if (out_data !== 18'h00002) begin errors++; $display("FAIL full_next_data got %h exp 2", out_data); end
      out_ready = 7'h40;
      step();
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL full_drain_count got %0d exp 0", count); end
      out_ready = 7'h00;
   endtask

   task automatic test_hol();
      out_ready = 7'h00;
      in_valid = 1'b1; in_data = 18'h00005; in_dest = 3'd5;
      step();
      in_data = 18'h00011; in_dest = 3'd1;
      step();
      in_valid = 1'b0;
      out_ready = 7'h5F;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (out_valid !== 7'h20 || out_data !== 18'h00005 || count !== 2'd2) begin
            errors++;
            $display("FAIL hol_blocked[%0d] got valid=%h data=%h count=%0d exp 20/5/2", i, out_valid, out_data, count);
         end
      end
      out_ready = 7'h7F;
      step();
      out_ready = 7'h00;
      checks++; if (out_valid !== 7'h02) begin errors++; $display("FAIL hol_next_valid got %h exp 02", out_valid); end
      checks++; if (out_data !== 18'h00011) begin errors++; $display("FAIL hol_next_data got %h exp 11", out_data); end
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL hol_count got %0d exp 1", count); end
      out_ready = 7'h02;
      step();
      out_ready = 7'h00;
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL hol_drain_count got %0d exp 0", count); end
   endtask

   task automatic test_err();
      out_ready = 7'h00;
      in_valid = 1'b1; in_data = 18'h3FFFF; in_dest = 3'd7;
      step();
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL err_count got %0d exp 0", count); end
      checks++; if (err_dest !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err_dest); end
      checks++; if (out_valid !== 7'h00) begin errors++; $display("FAIL err_no_valid got %h exp 00", out_valid); end
      err_clr = 1'b1;
      step();
      checks++; if (err_dest !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b exp 1", err_dest); end
      in_valid = 1'b0;
      step();
      err_clr = 1'b0;
      checks++; if (err_dest !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err_dest); end
      step();
      checks++; if (err_dest !== 1'b0) begin errors++; $display("FAIL err_stays_clear got %b exp 0", err_dest); end
   endtask

   task automatic test_back_to_back();
      logic [6:0] exp_v;
      out_ready = 7'h00;
      in_valid = 1'b1; in_data = 18'h00100; in_dest = 3'd4;
      step();
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL b2b_first_count got %0d exp 1", count); end
      in_data = 18'h00200; in_dest = 3'd2; out_ready = 7'h10;
      step();
      in_valid = 1'b0; out_ready = 7'h00;
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL b2b_pushpop_count got %0d exp 1", count); end
      checks++; if (out_valid !== 7'h04) begin errors++; $display("FAIL b2b_pushpop_valid got %h exp 04", out_valid); end
      checks++; if (out_data !== 18'h00200) begin errors++; $display("FAIL b2b_pushpop_data got %h exp 200", out_data); end
      out_ready = 7'h04;
      step();
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL b2b_drain_count got %0d exp 0", count); end
      out_ready = 7'h7F;
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_data = 18'h00300 + 18'(k);
         in_dest = 3'(k % 7);
         step();
         exp_v = 7'd1 << (k % 7);
         checks++;
         if (out_data !== (18'h00300 + 18'(k)) || out_valid !== exp_v || count !== 2'd1) begin
            errors++;
            $display("FAIL b2b_order[%0d] got data=%h valid=%h count=%0d exp %h/%h/1", k, out_data, out_valid, count, 18'h00300 + 18'(k), exp_v);
         end
      end
      in_valid = 1'b0;
      step();
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL b2b_final_count got %0d exp 0", count); end
      out_ready = 7'h00;
   endtask

   task automatic test_async_reset();
      out_ready = 7'h00;
      in_valid = 1'b1; in_data = 18'h00AAA; in_dest = 3'd1;
      step();
      in_data = 18'h00BBB; in_dest = 3'd2;
      step();
      in_valid = 1'b0;
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL arst_pre_count got %0d exp 2", count); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", count); end
      checks++; if (out_valid !== 7'h00) begin errors++; $display("FAIL arst_valid got %h exp 00", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got %b exp 1", in_ready); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 7'h7F;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 7'h00 || count !== 2'd0) begin
            errors++;
            $display("FAIL arst_idle[%0d] got valid=%h count=%0d exp 00/0", i, out_valid, count);
         end
      end
      out_ready = 7'h00;
      in_valid = 1'b1; in_data = 18'h00007; in_dest = 3'd0;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 7'h01) begin errors++; $display("FAIL arst_new_valid got %h exp 01", out_valid); end
      checks++; if (out_data !== 18'h00007) begin errors++; $display("FAIL arst_new_data got %h exp 7", out_data); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_hol();
      test_err();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_router_18.md
WB_ROUTER_18 -- requirements
Module: wb_router_18

Interface
REQ-001 The block SHALL have parameter WIDTH, default 18, the data word width.
REQ-002 The block SHALL have parameter DEPTH, default 2, buffer entries (power of two, >=2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, source offers a word.
REQ-006 The block SHALL have port in_ready, output, 1, router can accept a word.
REQ-007 The block SHALL have port in_data, input, WIDTH, word to route.
REQ-008 The block SHALL have port in_dest, input, 3, destination code 0..6; 7 is illegal.
REQ-009 The block SHALL have port out_valid, output, 7, one-hot per-destination valid.
REQ-010 The block SHALL have port out_ready, input, 7, per-destination ready.
REQ-011 The block SHALL have port out_data, output, WIDTH, shared data bus to all destinations.
REQ-012 The block SHALL have port err_dest, output, 1, sticky illegal-destination flag.
REQ-013 The block SHALL have port err_clr, input, 1, clears err_dest.
REQ-014 The block SHALL have port count, output, clog2(DEPTH)+1, buffer occupancy.

Function
REQ-015 Storage SHALL be a DEPTH-entry FIFO of {dest, data}, with read/write pointers wrapping modulo DEPTH.
REQ-016 in_ready SHALL be 1 exactly when count < DEPTH; no full-buffer bypass.
REQ-017 Push SHALL occur on in_valid & in_ready with in_dest in 0..6.
REQ-018 On in_valid & in_ready with in_dest = 7, the word SHALL be consumed and discarded (no push) and err_dest SHALL be 1 from the next cycle.
REQ-019 When count > 0, out_valid SHALL have only bit[head.dest] set, and out_data SHALL equal head.data; when count = 0, out_valid = 0 and out_data = 0.
REQ-020 Pop SHALL occur when out_ready[head.dest] = 1 while count > 0; out_ready bits of other destinations SHALL be ignored.
REQ-021 Latency: a word pushed in cycle N SHALL be visible on out_valid/out_data in cycle N+1 at the earliest (registered, no combinational in-to-out path).
REQ-022 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-023 Words SHALL leave strictly in acceptance order regardless of destination; head-of-line blocking is intended.
REQ-024 out_valid[d] SHALL stay asserted and out_data stable until the pop occurs.
REQ-025 err_dest set and err_clr in the same cycle SHALL leave err_dest = 1 (set wins).
REQ-026 count SHALL always equal pushes minus pops since reset, and SHALL never exceed DEPTH or go below 0.

Reset
REQ-027 On rst_n low, immediately and independent of clk: count=0, pointers=0, out_valid=0, out_data=0, err_dest=0, in_ready=1 (after reset release logic).
REQ-028 Reset mid-transfer SHALL discard all buffered words; no out_valid bit SHALL assert until a new push.
REQ-029 Buffer data storage need not be reset, but out_data SHALL be 0 while count = 0.

Verification
REQ-030 Push data 18'h2AAAA dest 3, out_ready=7'h08 -> cycle+1 out_valid=7'h08, out_data=18'h2AAAA, popped same cycle, count returns to 0.
REQ-031 out_ready=0, push 18'h00001 dest 0 and 18'h00002 dest 6 -> count=2, in_ready=0; third offer not accepted; out_valid=7'h01 stays until out_ready[0].
REQ-032 Head dest 5, out_ready=7'h7F except bit 5 held 0 for 4 cycles -> no pop, out_valid=7'h20 stable; bit 5 raised -> pop, next head presented.
REQ-033 Push with in_dest=7 -> count unchanged, err_dest=1 next cycle; err_clr with simultaneous illegal push -> err_dest stays 1; err_clr alone -> 0.
REQ-034 count=1, simultaneous push (dest 2) and pop -> count stays 1, new head dest 2 next cycle; then 8 back-to-back words with all ready -> order preserved across pointer wrap.
REQ-035 Assert rst_n low with count=2 between clock edges -> out_valid=0, count=0 immediately; after release, out_valid stays 0 until a new push.
